// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter
//   Shares one Wishbone classic master between the rv32i instruction-fetch and
//   load/store ports. Each access is one Wishbone cycle. Byte lanes and store
//   data replication come from funct3, and so does load extension. Data has
//   fixed priority over fetch.
//
//   Ports
//     clk, reset_n                    clock, async active-low reset
//     if_req/if_addr/if_rdata/if_ack  fetch requester (ack = 1-cycle pulse)
//     d_req/d_we/d_op/d_addr/d_wdata  load/store requester
//     d_rdata/d_ack                   extended load data, 1-cycle completion
//     wb_*                            Wishbone classic master (outputs registered)
//     stall_pipl                      combinational pipeline stall to the core
//     bus_err                         1-cycle error pulse (err, misalign, timeout)
//
//   Optional feature: define BUS_TIMEOUT_EN to add a BUS-state watchdog that
//   aborts an access after TIMEOUT_CYCLES cycles without ack/err.
module core_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_op,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        stall_pipl,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e      state_q, state_d;
  logic        is_d_q, is_d_d;        // granted requester: 1 = load/store
  logic [2:0]  op_q, op_d;
  logic [1:0]  lo_q, lo_d;            // byte offset for load lane select
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic [3:0]  st_sel;
  logic [31:0] st_dat;
  logic        misalign;
  logic        expire;
  logic        err_now;

  logic unused_ok;
  assign unused_ok = &{1'b0, if_addr[1:0], TIMEOUT_CYCLES[0]};

`ifdef BUS_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
  // Counts completed BUS cycles; expiry fires during the TIMEOUT_CYCLES-th one.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == IDLE)     wdog_d = '0;
    else if (state_q == BUS) wdog_d = wdog_q + 16'd1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) wdog_q <= '0;
    else          wdog_q <= wdog_d;
  assign expire = (state_q == BUS) && (wdog_q + 16'd1 == TIMEOUT_CYCLES[15:0]);
`else
  assign expire = 1'b0;
`endif

  // Lane/data shaping for the incoming data request (funct3[1:0] = size).
  always_comb begin
    st_sel = 4'b1111;
    st_dat = d_wdata;
    case (d_op[1:0])
      2'b00: begin
        st_sel = 4'b0001 << d_addr[1:0];
        st_dat = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        st_sel = 4'b0011 << {d_addr[1], 1'b0};
        st_dat = {2{d_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign misalign = ((d_op[1:0] == 2'b01) && d_addr[0]) ||
                    (d_op[1] && (d_addr[1:0] != 2'b00));

  function automatic logic [31:0] load_ext(input logic [2:0]  op,
                                           input logic [1:0]  lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (op[1:0])
      2'b00:   r = {{24{b[7] & ~op[2]}}, b};
      2'b01:   r = {{16{h[15] & ~op[2]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // err beats ack; ack beats a same-cycle watchdog expiry.
  assign err_now = wb_err_i || (!wb_ack_i && expire);

  always_comb begin
    state_d    = state_q;
    is_d_d     = is_d_q;
    op_d       = op_q;
    lo_d       = lo_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    bus_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          is_d_d = 1'b1;
          if (misalign) begin
            // No bus cycle: complete straight away as an error.
            state_d   = RESP;
            d_ack_d   = 1'b1;
            bus_err_d = 1'b1;
            d_rdata_d = '0;
          end else begin
            state_d = BUS;
            cyc_d   = 1'b1;
            we_d    = d_we;
            adr_d   = {d_addr[31:2], 2'b00};
            sel_d   = st_sel;
            dat_d   = st_dat;
            op_d    = d_op;
            lo_d    = d_addr[1:0];
          end
        end else if (if_req) begin
          state_d = BUS;
          is_d_d  = 1'b0;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          adr_d   = {if_addr[31:2], 2'b00};
          sel_d   = 4'b1111;
          op_d    = 3'b010;
          lo_d    = 2'b00;
        end
      end
      BUS: begin
        if (wb_ack_i || wb_err_i || expire) begin
          state_d   = RESP;
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          bus_err_d = err_now;
          if (is_d_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = err_now ? 32'h0 : load_ext(op_q, lo_q, wb_dat_i);
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = err_now ? 32'h0 : wb_dat_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      is_d_q     <= 1'b0;
      op_q       <= '0;
      lo_q       <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      bus_err_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_d_q     <= is_d_d;
      op_q       <= op_d;
      lo_q       <= lo_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      bus_err_q  <= bus_err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = sel_q;
  assign if_ack     = if_ack_q;
  assign d_ack      = d_ack_q;
  assign bus_err    = bus_err_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign stall_pipl = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_core_bus_arbiter.sv
module tb_core_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [2:0]  d_op;
  logic [31:0] if_rdata, d_rdata;
  logic        if_ack, d_ack;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;
  logic        stall_pipl, bus_err;

  core_bus_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .stall_pipl(stall_pipl), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  typedef struct { bit is_d; bit err; logic [31:0] rdata; bit chk_data; } resp_t;
  typedef struct { logic [31:0] adr; logic [3:0] sel; bit we; logic [31:0] dat; } bus_t;
  resp_t resp_q[$];
  bus_t  bus_q[$];

  // Slave model. mode: 0 ack, 1 err, 2 ack+err, 3 never respond.
  int          sl_ws = 0, sl_mode = 0, sl_cnt = 0;
  logic [31:0] sl_data = '0;
  always @(negedge clk) begin
    if (wb_cyc_o && wb_stb_o) begin
      if (sl_mode != 3 && sl_cnt >= sl_ws) begin
        wb_ack_i = (sl_mode == 0 || sl_mode == 2);
        wb_err_i = (sl_mode == 1 || sl_mode == 2);
        wb_dat_i = sl_data;
      end else begin
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        sl_cnt++;
      end
    end else begin
      wb_ack_i = 1'b0; wb_err_i = 1'b0; sl_cnt = 0;
    end
  end

  // Response monitor: pops the scoreboard on every requester ack.
  always @(negedge clk) begin
    if (reset_n && (if_ack || d_ack)) begin
      if (resp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_ack actual=%b%b required=none", if_ack, d_ack);
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        chk("ack_kind", {30'd0, if_ack, d_ack}, e.is_d ? 32'd1 : 32'd2);
        chk("bus_err", {31'd0, bus_err}, {31'd0, e.err});
        if (e.chk_data) chk(e.is_d ? "d_rdata" : "if_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
      end
    end
  end

  // Bus monitor: checks the Wishbone fields at the first cycle of each access.
  logic prev_cyc = 1'b0;
  always @(negedge clk) begin
    if (wb_cyc_o && !prev_cyc) begin
      if (bus_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_cyc actual=%h required=no_cycle", wb_adr_o);
      end else begin
        bus_t b;
        b = bus_q.pop_front();
        chk("wb_stb", {31'd0, wb_stb_o}, 32'd1);
        chk("wb_adr", wb_adr_o, b.adr);
        chk("wb_sel", {28'd0, wb_sel_o}, {28'd0, b.sel});
        chk("wb_we", {31'd0, wb_we_o}, {31'd0, b.we});
        if (b.we) chk("wb_dat", wb_dat_o, b.dat);
      end
    end
    prev_cyc = wb_cyc_o;
  end

  task automatic access(input bit is_d, input bit we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ws, input int mode, input logic [31:0] sdata,
                        input bit exp_bus, input logic [3:0] exp_sel, input logic [31:0] exp_dat,
                        input bit exp_err, input bit chk_data, input logic [31:0] exp_rdata,
                        input int exp_lat);
    int t0;
    bit done, ack;
    @(posedge clk); #1;
    sl_ws = ws; sl_mode = mode; sl_data = sdata;
    if (exp_bus) bus_q.push_back('{{addr[31:2], 2'b00}, exp_sel, we, exp_dat});
    resp_q.push_back('{is_d, exp_err, exp_rdata, chk_data});
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_op = op; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    t0 = cyc_cnt; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      ack = is_d ? d_ack : if_ack;
      chk("stall", {31'd0, stall_pipl}, {31'd0, !ack});
      if (ack) begin
        done = 1'b1;
        chk("latency", cyc_cnt - t0, exp_lat);
      end
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL ack_timeout actual=none required=ack_at_%0d", exp_lat);
    end
    d_req = 1'b0; if_req = 1'b0;
  endtask

  initial begin
    int t0, d_at, i_at;
    reset_n = 1'b0;
    if_req = 0; d_req = 0; d_we = 0; d_op = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_cyc", {31'd0, wb_cyc_o}, 0);
    chk("rst_stb", {31'd0, wb_stb_o}, 0);
    chk("rst_we", {31'd0, wb_we_o}, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_sel", {28'd0, wb_sel_o}, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_acks", {29'd0, if_ack, d_ack, bus_err}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_stall_lo", {31'd0, stall_pipl}, 0);
    if_req = 1'b1; #1;
    chk("rst_stall_hi", {31'd0, stall_pipl}, 1);
    if_req = 1'b0;
    @(negedge clk); reset_n = 1'b1;

    //     is_d we op      addr          wdata         ws md sdata         bus sel      dat           err chk rdata         lat
    access(1, 0, 3'b010, 32'h0000_0100, 32'h0,        0, 0, 32'hDEADBEEF, 1, 4'b1111, 32'h0,        0, 1, 32'hDEADBEEF, 2);
    access(1, 0, 3'b000, 32'h0000_0103, 32'h0,        0, 0, 32'h80FF0000, 1, 4'b1000, 32'h0,        0, 1, 32'hFFFFFF80, 2);
    access(1, 0, 3'b100, 32'h0000_0103, 32'h0,        0, 0, 32'h80FF0000, 1, 4'b1000, 32'h0,        0, 1, 32'h00000080, 2);
    access(1, 0, 3'b001, 32'h0000_0102, 32'h0,        0, 0, 32'h80FF0000, 1, 4'b1100, 32'h0,        0, 1, 32'hFFFF80FF, 2);
    access(1, 0, 3'b101, 32'h0000_0100, 32'h0,        0, 0, 32'h12348001, 1, 4'b0011, 32'h0,        0, 1, 32'h00008001, 2);
    access(1, 0, 3'b000, 32'h0000_0100, 32'h0,        0, 0, 32'h0000007F, 1, 4'b0001, 32'h0,        0, 1, 32'h0000007F, 2);
    access(1, 1, 3'b001, 32'h0000_0102, 32'h00001234, 0, 0, 32'h0,        1, 4'b1100, 32'h12341234, 0, 0, 32'h0,        2);
    access(1, 1, 3'b000, 32'h0000_0101, 32'hFFFFFFAB, 0, 0, 32'h0,        1, 4'b0010, 32'hABABABAB, 0, 0, 32'h0,        2);
    access(1, 1, 3'b010, 32'h0000_0200, 32'h11223344, 1, 0, 32'h0,        1, 4'b1111, 32'h11223344, 0, 0, 32'h0,        3);
    access(0, 0, 3'b000, 32'h0000_0400, 32'h0,        2, 0, 32'hCAFEF00D, 1, 4'b1111, 32'h0,        0, 1, 32'hCAFEF00D, 4);
    // Misaligned data accesses: no bus cycle, immediate error completion.
    access(1, 0, 3'b010, 32'h0000_0101, 32'h0,        0, 0, 32'h55555555, 0, 4'b0000, 32'h0,        1, 1, 32'h0,        1);
    access(1, 0, 3'b001, 32'h0000_0101, 32'h0,        0, 0, 32'h55555555, 0, 4'b0000, 32'h0,        1, 1, 32'h0,        1);
    access(1, 1, 3'b001, 32'h0000_0103, 32'h0000BEEF, 0, 0, 32'h0,        0, 4'b0000, 32'h0,        1, 0, 32'h0,        1);
    chk("if_rdata_hold", if_rdata, 32'hCAFEF00D);
    // Slave error on a fetch, then ack+err together on a load (err wins).
    access(0, 0, 3'b000, 32'h0000_0404, 32'h0,        0, 1, 32'h12345678, 1, 4'b1111, 32'h0,        1, 1, 32'h0,        2);
    access(1, 0, 3'b010, 32'h0000_0104, 32'h0,        0, 2, 32'h12345678, 1, 4'b1111, 32'h0,        1, 1, 32'h0,        2);

    // Simultaneous fetch + load: data first, fetch 3 cycles after d_ack.
    @(posedge clk); #1;
    sl_ws = 0; sl_mode = 0; sl_data = 32'h13579BDF;
    bus_q.push_back('{32'h0000_0300, 4'b1111, 1'b0, 32'h0});
    bus_q.push_back('{32'h0000_0500, 4'b1111, 1'b0, 32'h0});
    resp_q.push_back('{1'b1, 1'b0, 32'h13579BDF, 1'b1});
    resp_q.push_back('{1'b0, 1'b0, 32'h13579BDF, 1'b1});
    d_req = 1; d_we = 0; d_op = 3'b010; d_addr = 32'h300;
    if_req = 1; if_addr = 32'h500;
    t0 = cyc_cnt; d_at = -1; i_at = -1;
    for (int i = 0; i < 40 && i_at < 0; i++) begin
      @(negedge clk);
      chk("stall_both", {31'd0, stall_pipl}, {31'd0, (cyc_cnt - t0) != 5});
      if (d_ack) begin d_at = cyc_cnt - t0; d_req = 0; end
      if (if_ack) begin i_at = cyc_cnt - t0; if_req = 0; end
    end
    chk("both_d_lat", d_at, 2);
    chk("both_if_lat", i_at, 5);
    d_req = 0; if_req = 0;

    // Reset in the middle of a bus cycle.
    @(posedge clk); #1;
    sl_mode = 3;
    bus_q.push_back('{32'h0000_0600, 4'b1111, 1'b0, 32'h0});
    d_req = 1; d_we = 0; d_op = 3'b010; d_addr = 32'h600;
    repeat (2) @(negedge clk);
    chk("mid_cyc_before", {31'd0, wb_cyc_o}, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_cyc", {31'd0, wb_cyc_o}, 0);
    chk("mid_rst_stb", {31'd0, wb_stb_o}, 0);
    d_req = 0;
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_noack", {30'd0, if_ack, d_ack}, 0);
    end
    reset_n = 1'b1;
    access(1, 0, 3'b010, 32'h0000_0700, 32'h0,        0, 0, 32'h0BADF00D, 1, 4'b1111, 32'h0,        0, 1, 32'h0BADF00D, 2);

`ifdef BUS_TIMEOUT_EN
    access(1, 0, 3'b010, 32'h0000_0800, 32'h0,        0, 3, 32'h0,        1, 4'b1111, 32'h0,        1, 1, 32'h0,        256);
    access(1, 0, 3'b010, 32'h0000_0804, 32'h0,        0, 0, 32'h24681357, 1, 4'b1111, 32'h0,        0, 1, 32'h24681357, 2);
`endif

    repeat (3) @(negedge clk);
    chk("resp_q_drained", resp_q.size(), 0);
    chk("bus_q_drained", bus_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
